// File: rtl/mac_vector_pkg.sv
// Shared types and width-derived constants for the N-lane MAC vector engine.
package mac_vector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    // Operand register -> product register -> accumulator.
    localparam int PIPE_DEPTH = 2;
    localparam int PROD_MULT  = 2;

    function automatic int prod_width(input int dw);
        return PROD_MULT * dw;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -sat_max(w) - 64'sd1;
    endfunction

endpackage

// File: rtl/mac_vector_lane.sv
// One MAC lane: operand/product registers, saturating accumulator, rescale and clamp.
// Build with MAC_VECTOR_RELU_EN defined to zero negative lane results.
module mac_vector_lane
    import mac_vector_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  ld_i,
    input  logic                  mul_en_i,
    input  logic                  acc_en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  sat_o
);

    localparam int PW = prod_width(DATA_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = ACC_WIDTH'(sat_min(ACC_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [DATA_WIDTH-1:0] a_q, b_q;
    logic signed [PW-1:0]         p_q;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         sat_q, sat_d;
    logic signed [ACC_WIDTH:0]    sum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0] hi;
    logic                         clamp;
    logic [DATA_WIDTH-1:0]        res_sat;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    always_comb begin
        sum   = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(p_q);
        acc_d = sum[ACC_WIDTH-1:0];
        sat_d = sat_q;
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (ld_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (mul_en_i)
                p_q <= PW'(a_q) * PW'(b_q);
            if (clr_i) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (acc_en_i) begin
                acc_q <= acc_d;
                sat_q <= sat_d;
            end
        end
    end

    // Result fits DATA_WIDTH only if all bits above the result sign match it.
    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        hi      = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
        clamp   = !((&hi) || (~|hi));
        res_sat = clamp ? (shifted[ACC_WIDTH-1] ? DATA_MIN : DATA_MAX)
                        : shifted[DATA_WIDTH-1:0];
`ifdef MAC_VECTOR_RELU_EN
        res_o   = res_sat[DATA_WIDTH-1] ? '0 : res_sat;
`else
        res_o   = res_sat;
`endif
        sat_o   = sat_q | clamp;
    end

endmodule

// File: rtl/mac_vector_engine.sv
// N-lane fixed-point dot-product engine: FSM, beat counter and both handshakes.
// Optional MAC_VECTOR_RELU_EN clamps negative lane results to zero.
module mac_vector_engine
    import mac_vector_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int N_LANES    = 4,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_mac,
    input  logic [LEN_WIDTH-1:0]          vec_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_LANES*DATA_WIDTH-1:0] in_a,
    input  logic [N_LANES*DATA_WIDTH-1:0] in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_LANES*DATA_WIDTH-1:0] out_data,
    output logic [N_LANES-1:0]            out_sat,
    output logic                          busy
);

    state_e                                state_q;
    logic [LEN_WIDTH-1:0]                  len_q, cnt_q;
    logic [PIPE_DEPTH:1]                   vld_pipe_q;
    logic                                  accept;
    logic                                  out_valid_q;
    logic [N_LANES-1:0][DATA_WIDTH-1:0]    out_data_q;
    logic [N_LANES-1:0]                    out_sat_q;
    logic [N_LANES-1:0][DATA_WIDTH-1:0]    lane_res;
    logic [N_LANES-1:0]                    lane_sat;

    // A beat arriving together with init_mac belongs to the aborted vector.
    assign accept    = in_valid && (state_q == ACCUM) && !init_mac;
    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    genvar i;
    generate
        for (i = 0; i < N_LANES; i++) begin : g_lane
            mac_vector_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .FRAC_BITS (FRAC_BITS),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr_i   (init_mac),
                .ld_i    (accept),
                .mul_en_i(vld_pipe_q[1]),
                .acc_en_i(vld_pipe_q[PIPE_DEPTH]),
                .a_i     (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
                .b_i     (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
                .res_o   (lane_res[i]),
                .sat_o   (lane_sat[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[PIPE_DEPTH-1:1], accept};
            if (init_mac) begin
                vld_pipe_q <= '0;
                cnt_q      <= '0;
                len_q      <= vec_len;
                if (vec_len == '0) begin
                    state_q     <= OUTPUT;
                    out_valid_q <= 1'b1;
                    out_data_q  <= '0;
                    out_sat_q   <= '0;
                end else begin
                    state_q     <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (accept) begin
                            if (cnt_q == len_q - LEN_WIDTH'(1))
                                state_q <= DRAIN;
                            else
                                cnt_q <= cnt_q + LEN_WIDTH'(1);
                        end
                    end
                    // Last product has landed in the accumulators once the pipe is empty.
                    DRAIN: begin
                        if (vld_pipe_q == '0) begin
                            state_q     <= OUTPUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= lane_res;
                            out_sat_q   <= lane_sat;
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_vector_engine.sv
// Directed bench for mac_vector_engine with hand-computed lane results.
module tb_mac_vector_engine;

    localparam int DW = 16;
    localparam int NL = 4;
    localparam int LW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_mac = 1'b0;
    logic [LW-1:0]     vec_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NL*DW-1:0]  in_a = '0;
    logic [NL*DW-1:0]  in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NL*DW-1:0]  out_data;
    logic [NL-1:0]     out_sat;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [63:0] held;
    logic [63:0] neg_exp;

    mac_vector_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_mac (init_mac),
        .vec_len  (vec_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        init_mac = 1'b1;
        vec_len  = LW'(n);
        tick();
        init_mac = 1'b0;
    endtask

    task automatic beat(input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("beat_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Beats in IDLE are ignored
        in_valid = 1'b1; in_a = 64'h0100; in_b = 64'h0100;
        repeat (3) begin
            tick();
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;

        // Basic: 3 x (1.0 * 2.0) on lane0
        start(3);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        repeat (3) beat(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0200);
        wait_out(cyc);
        check("t1_latency", 64'(cyc), 64'd3);
        check("t1_data", out_data, 64'h0000_0000_0000_0600);
        check("t1_sat", 64'(out_sat), 64'd0);
        deliver();
        check("t1_done_valid", 64'(out_valid), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd0);

        // Output clamp on every lane, then back-pressure
        start(4);
        repeat (4) beat({4{16'h7FFF}}, {4{16'h7FFF}});
        wait_out(cyc);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_data", out_data, {4{16'h7FFF}});
        check("t2_sat", 64'(out_sat), 64'hF);
        held = out_data;
        repeat (5) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
        end
        deliver();
        check("bp_done_valid", 64'(out_valid), 64'd0);
        check("bp_done_busy", 64'(busy), 64'd0);

        // Negative result on lane1: 2 x (-1.0 * 1.0)
`ifdef MAC_VECTOR_RELU_EN
        neg_exp = 64'h0;
`else
        neg_exp = 64'h0000_0000_FE00_0000;
`endif
        start(2);
        repeat (2) beat(64'h0000_0000_FF00_0000, 64'h0000_0000_0100_0000);
        wait_out(cyc);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_data", out_data, neg_exp);
        check("t3_sat", 64'(out_sat), 64'd0);
        deliver();

        // Accumulator saturation: 520 x 2^30 exceeds 2^39-1; wrapping would go negative
        start(520);
        repeat (520) beat(64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000);
        wait_out(cyc);
        check("accsat_valid", 64'(out_valid), 64'd1);
        check("accsat_data", out_data, 64'h0000_0000_0000_7FFF);
        check("accsat_sat", 64'(out_sat), 64'h1);
        deliver();

        // Abort a partial vector and restart with length 1
        start(5);
        repeat (2) beat({4{16'h0100}}, {4{16'h0100}});
        start(1);
        beat({4{16'h0100}}, {4{16'h0100}});
        wait_out(cyc);
        check("abort_data", out_data, {4{16'h0100}});
        check("abort_sat", 64'(out_sat), 64'd0);
        deliver();

        // Zero-length vector
        start(0);
        check("zero_valid", 64'(out_valid), 64'd1);
        check("zero_data", out_data, 64'd0);
        check("zero_sat", 64'(out_sat), 64'd0);
        check("zero_in_ready", 64'(in_ready), 64'd0);

        // init_mac together with the output handshake
        out_ready = 1'b1;
        start(1);
        out_ready = 1'b0;
        check("hs_init_valid", 64'(out_valid), 64'd0);
        check("hs_init_in_ready", 64'(in_ready), 64'd1);
        beat(64'h0000_0200_0000_0000, 64'h0000_0100_0000_0000);
        wait_out(cyc);
        check("hs_init_data", out_data, 64'h0000_0200_0000_0000);
        deliver();

        // Reset during DRAIN
        start(1);
        beat(64'h0100, 64'h0100);
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_in_ready", 64'(in_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_sat", 64'(out_sat), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        start(1);
        beat(64'h0100, 64'h0100);
        wait_out(cyc);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", out_data, 64'h0000_0000_0000_0100);
        deliver();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_vector_engine.md
Name: mac_vector_engine

Overview:
- Parametrised N-lane fixed-point multiply-accumulate engine for the neural-network scoring path. It computes N_LANES independent dot products of length vec_len over a valid/ready input stream.
- Each lane has its own pipelined multiplier and a saturating accumulator. At the end of a vector, each lane's result is rescaled, saturated and presented on an output handshake.
- It supersedes the single-lane, dual-clock MAC with a one-clock, back-pressured, length-aware engine.

Parameters:
- DATA_WIDTH, 16, signed operand and result width (two's complement).
- FRAC_BITS, 8, fractional bits of operands and result (Q format).
- ACC_WIDTH, 40, signed accumulator width; must be at least 2*DATA_WIDTH.
- N_LANES, 4, number of parallel MAC lanes.
- LEN_WIDTH, 10, width of the vector-length field.

Ports:
- clk, input, 1, single clock for all logic.
- rst_n, input, 1, asynchronous active-low reset.
- init_mac, input, 1, start a new vector: clears accumulators, latches vec_len, aborts any vector in flight.
- vec_len, input, LEN_WIDTH, number of beats in the vector; sampled only when init_mac=1.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, engine accepts a beat.
- in_a, input, N_LANES*DATA_WIDTH, lane operands A; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_b, input, N_LANES*DATA_WIDTH, lane operands B; same packing as in_a.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, N_LANES*DATA_WIDTH, rescaled, saturated lane results.
- out_sat, output, N_LANES, per-lane flag: saturation occurred anywhere in this lane for this vector.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0; all pipeline registers, accumulators and counters are cleared; state=IDLE.
- FSM states: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - init_mac with vec_len>0 -> ACCUM.
  - init_mac with vec_len=0 -> OUTPUT with out_data=0 and out_sat=0; out_valid is high on the next cycle.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - The beat counter increments per accepted beat; on the vec_len-th accept -> DRAIN.
- Pipeline, per lane (beat accepted at edge E):
  - Operands are registered at E.
  - The full-precision signed product (2*DATA_WIDTH bits) is registered at E+1.
  - The product is sign-extended and added into the accumulator at E+2.
- DRAIN:
  - in_ready=0.
  - Waits 2 cycles for the pipeline to empty, then loads the output register.
  - out_valid rises at edge E_last+3.
- Accumulator rule: the addition saturates at ±(2^(ACC_WIDTH-1)) limits, never wraps, and sets the lane's sticky saturation bit.
- Output rescale:
  - Arithmetic shift right by FRAC_BITS (truncation toward -inf).
  - Then saturate to the signed DATA_WIDTH range, i.e. [-32768, 32767] at defaults; clamping sets the lane's sat bit.
- OUTPUT:
  - out_valid=1. out_data and out_sat are held stable until out_valid && out_ready, then -> IDLE and out_valid=0 on the next cycle.
  - in_ready=0 throughout.
- init_mac in any state is synchronous and has priority:
  - Pipeline valids, accumulators, counter and sat bits are cleared the same edge.
  - vec_len is latched, and the next state is ACCUM (or the zero-length OUTPUT case).
  - Any partial vector is discarded.
  - If init_mac coincides with an out_valid && out_ready handshake, the result counts as delivered and the new vector starts.
- A beat presented while in_ready=0 is ignored; no internal state changes.
- The beat counter is LEN_WIDTH bits. Maximum vec_len is 2^LEN_WIDTH-1, and the counter never wraps within a vector.

Optional Feature:
- Macro MAC_VECTOR_RELU_EN.
- Defined: after rescale and saturation, negative lane results are replaced with 0. This applies before the output register, and the sat bit is unaffected.
- Undefined: signed results are passed through unchanged.

Decomposition:
- Package mac_vector_pkg contains:
  - the FSM state enum;
  - localparams for the pipeline depth (2) and product width (2*DATA_WIDTH);
  - the saturation limit constants, derived as functions of the widths.
- Sub-module mac_vector_lane: one lane's operand register, product register, saturating accumulator, rescale/saturate logic and sticky sat bit.
  - It is instantiated N_LANES times via generate.
  - The top level owns the FSM, the beat counter and both handshakes.

Test Plan:
- Basic result: defaults; init_mac with vec_len=3; 3 beats with lane0 a=256, b=512 (1.0×2.0) and other lanes 0 -> out_valid 3 cycles after the last accept; lane0=1536 (6.0), lanes 1–3=0, out_sat=0.
- Output saturation: vec_len=4, all lanes a=b=32767 -> out_data lanes=32767, out_sat=4'hF.
- Negative result: lane1 a=-256, b=256, vec_len=2 -> lane1=-512. With MAC_VECTOR_RELU_EN -> lane1=0 and sat=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stay stable, in_ready=0. Raise out_ready -> IDLE next cycle, busy=0.
- Abort and zero length:
  - init_mac(len=5); 2 beats of a=b=256; then init_mac(len=1); one beat a=b=256 -> result=256. The earlier beats are discarded.
  - init_mac(len=0) -> out_valid next cycle with all zeros.
- Reset mid-operation: assert rst_n=0 during DRAIN -> all outputs 0 immediately. After release, a vec_len=1 vector with a=b=256 -> 256.
